alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin front end that shares one 6-bit `ALU` instance between two requesters. Each requester presents an operand pair and a 3-bit function code on a valid/ready handshake. The arbiter grants one request per cycle, evaluates it through the combinational ALU, and holds the result in a one-entry output register tagged with the requester id. It sits between the two issuing units and the shared ALU, and is the only agent that drives the ALU inputs.

## Interface
- `WIDTH`, default 6, operand/result width; fixed to match `ALU`, other values unsupported.
- `CNTW`, default 8, width of the accepted-operation counter.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_fxn`  in  3  requester 0 ALU function code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_fxn`: same as requester 0, for requester 1.
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  consumer takes the result this cycle.
- `res_x`  out  WIDTH  registered ALU result.
- `res_id`  out  1  requester that issued `res_x`.
- `op_count`  out  CNTW  number of accepted operations, saturating.

## Operation
- Function codes, with all arithmetic mod 2^WIDTH:
  - 000: A
  - 001: B
  - 010: −A (two's complement)
  - 011: −B (two's complement)
  - 100: unsigned A<B gives 1, else 0
  - 101: bitwise ~(A^B)
  - 110: A+B
  - 111: A−B
- Output state machine:
  - EMPTY (`res_valid`=0) → FULL when a grant is issued.
  - FULL → FULL (new result replaces old) when `res_ready`=1 and a grant is issued.
  - FULL → EMPTY when `res_ready`=1 and no grant is issued.
  - FULL holds all outputs when `res_ready`=0.
- `accept_en` = !`res_valid` | `res_ready`. This gives pipelined throughput of one op per cycle.
- Arbitration:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that is not `last_grant`.
  - `last_grant` updates only on an accepted grant.
- `reqN_ready` = `accept_en` & grant==N. The ready is combinational from the valids and `res_ready`. Requesters must not derive valid from ready.
- Once asserted, a requester's valid and payload are held stable until its ready is seen.
- On a grant, the ALU inputs are muxed from the granted requester. `res_x`/`res_id` load at the next edge.
- `op_count` increments on every grant and saturates at 2^CNTW−1.

## Timing
- Reset values: `res_valid`=0, `res_x`=0, `res_id`=0, `op_count`=0, `last_grant`=1 (requester 0 wins the first tie). Both readies are 0 during reset.
- Latency: a request accepted at edge n shows `res_valid`=1 after edge n.
- A result that stalls under `res_ready`=0 is held indefinitely. No request is accepted during the stall.
- Simultaneous drain and grant in the same cycle: no bubble; the new result loads.
- Reset asserted mid-operation: the held result is discarded and the handshake is not completed. Requesters must re-present.
- A single continuously valid requester is granted every cycle. With both continuously valid, grants alternate strictly 0,1,0,1.

## Structure
- Shared package holds:
  - function-code constants (`FXN_PASS_A` … `FXN_SUB`);
  - `WIDTH`;
  - the requester-id type.
- One sub-module: the existing `ALU`, instantiated once, purely combinational.
- Arbiter, state register and counter are inline.

## Test plan
- Reset, then req0 only with fxn=110, A=63, B=1 → req0_ready=1 in that cycle; next cycle `res_valid`=1, `res_x`=0, `res_id`=0.
- Both valid continuously (req0: fxn=111, A=3, B=5; req1: fxn=100, A=3, B=5), `res_ready`=1 → alternating results 62 (id0), 1 (id1), 62, 1; the first grant goes to req0.
- Backpressure: result held with `res_ready`=0 for 3 cycles and req1 valid (fxn=101, A=6'b101010, B=6'b111000) → both readies 0 and `res_x` stable for 3 cycles; on release `res_x`=6'b101101, `res_id`=1, with no bubble.
- Sweep all fxn with A=1, B=2 → results 1, 2, 63, 62, 1, 60, 3, 63.
- Assert `rst` while FULL → `res_valid`=0 and `op_count`=0 on the next edge; after reset, the first tie is granted to req0.
- 300 back-to-back accepted ops with CNTW=8 → `op_count` stops at 255.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the operand width, the function codes, the requester id type and the output states.
package alu_arbiter_pkg;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned FXNW  = 3;

  typedef logic [FXNW-1:0] fxn_t;
  typedef logic [0:0]      req_id_t;

  localparam fxn_t FXN_PASS_A = 3'b000;
  localparam fxn_t FXN_PASS_B = 3'b001;
  localparam fxn_t FXN_NEG_A  = 3'b010;
  localparam fxn_t FXN_NEG_B  = 3'b011;
  localparam fxn_t FXN_LT     = 3'b100;
  localparam fxn_t FXN_XNOR   = 3'b101;
  localparam fxn_t FXN_ADD    = 3'b110;
  localparam fxn_t FXN_SUB    = 3'b111;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef enum logic {EMPTY, FULL} res_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and result handshake bundle between the two issuing units, the arbiter and the consumer.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  fxn_t             req0_fxn;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  fxn_t             req1_fxn;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_x;
  req_id_t          res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_fxn,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_fxn,
    input  req1_ready,
    input  res_valid, res_x, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fxn,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_fxn,
    output req1_ready,
    output res_valid, res_x, res_id,
    input  res_ready
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU; all arithmetic wraps modulo 2^WIDTH.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  fxn_t             fxn,
  output logic [WIDTH-1:0] x_c
);

  always_comb begin
    x_c = '0;
    unique case (fxn)
      FXN_PASS_A: x_c = a;
      FXN_PASS_B: x_c = b;
      FXN_NEG_A:  x_c = -a;
      FXN_NEG_B:  x_c = -b;
      FXN_LT:     x_c = WIDTH'(a < b);
      FXN_XNOR:   x_c = ~(a ^ b);
      FXN_ADD:    x_c = a + b;
      FXN_SUB:    x_c = a - b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a one-entry
// tagged result register and a saturating count of accepted operations.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    bus,
  output logic [CNTW-1:0] op_count
);

  res_state_t       state, state_nxt;
  req_id_t          last_grant, grant_id;
  logic             grant_any, accept_en, accept;
  logic [WIDTH-1:0] alu_a, alu_b, alu_x;
  fxn_t             alu_fxn;

  // Arbitration: a lone valid wins; on a tie the requester not granted last time wins.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = bus.req1_valid ? REQ1 : REQ0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end
    accept_en      = (state == EMPTY) | bus.res_ready;
    accept         = accept_en & grant_any & ~rst;
    bus.req0_ready = accept & (grant_id == REQ0);
    bus.req1_ready = accept & (grant_id == REQ1);
    alu_a          = (grant_id == REQ1) ? bus.req1_a   : bus.req0_a;
    alu_b          = (grant_id == REQ1) ? bus.req1_b   : bus.req0_b;
    alu_fxn        = (grant_id == REQ1) ? bus.req1_fxn : bus.req0_fxn;
  end

  alu_arbiter_alu u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .fxn (alu_fxn),
    .x_c (alu_x)
  );

  // Result register occupancy; a drain and a new grant in one cycle stay FULL.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (bus.res_ready) state_nxt = accept ? FULL : EMPTY;
    endcase
  end

  assign bus.res_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      bus.res_x  <= '0;
      bus.res_id <= REQ0;
      last_grant <= REQ1;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bus.res_x  <= alu_x;
        bus.res_id <= grant_id;
        last_grant <= grant_id;
        if (op_count != '1) begin
          op_count <= op_count + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed sequences, a function-code table and random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned CNTW = 8;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [CNTW-1:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter #(.CNTW(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  int checks = 0;
  int passed = 0;

  // Model state: what the result register and counter should hold.
  bit m_valid = 1'b0;
  int m_x = 0, m_id = 0, m_cnt = 0, m_last = 1;
  bit seen_r0, seen_r1;

  typedef struct {
    logic [2:0] fxn;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] x;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int ref_alu(input int f, input int a, input int b);
    int r;
    case (f)
      0: r = a;
      1: r = b;
      2: r = 64 - a;
      3: r = 64 - b;
      4: r = (a < b) ? 1 : 0;
      5: r = 63 - (a ^ b);
      6: r = a + b;
      default: r = a - b + 64;
    endcase
    return r % 64;
  endfunction

  // One clock: apply inputs, check readies, take the edge, check registered outputs.
  task automatic cycle(input logic r,
                       input logic v0, input logic [5:0] a0, input logic [5:0] b0, input logic [2:0] f0,
                       input logic v1, input logic [5:0] a1, input logic [5:0] b1, input logic [2:0] f1,
                       input logic rr);
    int pick;
    bit acc;
    rst = r;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_fxn = f0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_fxn = f1;
    bus.res_ready = rr;
    #1;
    if (v0 && v1) pick = 1 - m_last;
    else if (v0)  pick = 0;
    else if (v1)  pick = 1;
    else          pick = -1;
    acc = !r && pick >= 0 && (!m_valid || rr);
    chk("req0_ready", int'(bus.req0_ready), int'(acc && pick == 0));
    chk("req1_ready", int'(bus.req1_ready), int'(acc && pick == 1));
    seen_r0 = bus.req0_ready;
    seen_r1 = bus.req1_ready;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_x = 0; m_id = 0; m_cnt = 0; m_last = 1;
    end else if (acc) begin
      m_valid = 1;
      m_x = (pick == 0) ? ref_alu(int'(f0), int'(a0), int'(b0)) : ref_alu(int'(f1), int'(a1), int'(b1));
      m_id = pick;
      m_last = pick;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (rr) begin
      m_valid = 0;
    end
    chk("res_valid", int'(bus.res_valid), int'(m_valid));
    chk("res_x", int'(bus.res_x), m_x);
    chk("res_id", int'(bus.res_id), m_id);
    chk("op_count", int'(op_count), m_cnt);
  endtask

  task automatic do_reset();
    cycle(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    chk("rst_req0_ready", int'(seen_r0), 0);
    chk("rst_req1_ready", int'(seen_r1), 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit p0, p1;
    logic [5:0] ra0, rb0, ra1, rb1;
    logic [2:0] rf0, rf1;
    logic rr;

    vecs[0] = '{3'd0, 6'd1, 6'd2, 6'd1};
    vecs[1] = '{3'd1, 6'd1, 6'd2, 6'd2};
    vecs[2] = '{3'd2, 6'd1, 6'd2, 6'd63};
    vecs[3] = '{3'd3, 6'd1, 6'd2, 6'd62};
    vecs[4] = '{3'd4, 6'd1, 6'd2, 6'd1};
    vecs[5] = '{3'd5, 6'd1, 6'd2, 6'd60};
    vecs[6] = '{3'd6, 6'd1, 6'd2, 6'd3};
    vecs[7] = '{3'd7, 6'd1, 6'd2, 6'd63};

    // Reset values.
    do_reset();
    chk("reset_res_valid", int'(bus.res_valid), 0);
    chk("reset_res_x", int'(bus.res_x), 0);
    chk("reset_op_count", int'(op_count), 0);

    // Single request with wraparound add.
    cycle(0, 1, 63, 1, 3'b110, 0, 0, 0, 0, 1);
    chk("t1_ready", int'(seen_r0), 1);
    chk("t1_valid", int'(bus.res_valid), 1);
    chk("t1_x", int'(bus.res_x), 0);
    chk("t1_id", int'(bus.res_id), 0);

    // Both valid: strict alternation starting from req0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 3, 5, 3'b111, 1, 3, 5, 3'b100, 1);
      chk("t2_x", int'(bus.res_x), (i % 2 == 0) ? 62 : 1);
      chk("t2_id", int'(bus.res_id), i % 2);
    end

    // Backpressure: result held three cycles, then released with no bubble.
    do_reset();
    cycle(0, 1, 7, 0, 3'b000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 6'b101010, 6'b111000, 3'b101, 0);
      chk("t3_stall_r1", int'(seen_r1), 0);
      chk("t3_stall_x", int'(bus.res_x), 7);
      chk("t3_stall_valid", int'(bus.res_valid), 1);
    end
    cycle(0, 0, 0, 0, 0, 1, 6'b101010, 6'b111000, 3'b101, 1);
    chk("t3_release_r1", int'(seen_r1), 1);
    chk("t3_release_x", int'(bus.res_x), 6'b101101);
    chk("t3_release_id", int'(bus.res_id), 1);
    chk("t3_release_valid", int'(bus.res_valid), 1);

    // Function-code table.
    foreach (vecs[i]) begin
      cycle(0, 1, vecs[i].a, vecs[i].b, vecs[i].fxn, 0, 0, 0, 0, 1);
      chk($sformatf("fxn%0d_x", i), int'(bus.res_x), int'(vecs[i].x));
    end

    // Reset while FULL, then first tie goes to req0.
    cycle(1, 1, 1, 1, 0, 1, 2, 2, 0, 0);
    chk("t5_rst_r0", int'(seen_r0), 0);
    chk("t5_rst_r1", int'(seen_r1), 0);
    chk("t5_valid", int'(bus.res_valid), 0);
    chk("t5_count", int'(op_count), 0);
    cycle(0, 1, 1, 1, 0, 1, 2, 2, 0, 1);
    chk("t5_tie_r0", int'(seen_r0), 1);
    chk("t5_tie_r1", int'(seen_r1), 0);
    chk("t5_tie_x", int'(bus.res_x), 1);

    // Random traffic; payloads stay stable until the requester sees ready.
    p0 = 0; p1 = 0;
    ra0 = 0; rb0 = 0; rf0 = 0; ra1 = 0; rb1 = 0; rf1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; ra0 = 6'($urandom); rb0 = 6'($urandom); rf0 = 3'($urandom);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1; ra1 = 6'($urandom); rb1 = 6'($urandom); rf1 = 3'($urandom);
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle(0, p0, ra0, rb0, rf0, p1, ra1, rb1, rf1, rr);
      if (seen_r0) p0 = 0;
      if (seen_r1) p1 = 0;
    end

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1, 6'(i), 6'(i + 1), 3'b110, 0, 0, 0, 0, 1);
    end
    chk("sat_count", int'(op_count), 255);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
